// File: rtl/ram_copy_dma.sv
// Block copy / block fill initiator for the single-port synchronous system RAM.
// Copy issues read/write pairs (2 cycles per word); fill writes one word per cycle.
module ram_copy_dma #(
  parameter int AW    = 12,
  parameter int DW    = 32,
  parameter int DEPTH = 3584
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_rnw,
  output logic          mem_cs_b
);

  typedef enum logic [2:0] {IDLE, RD, WR, FILL, FIN} state_t;

  state_t        state;
  logic [AW-1:0] cur_src;
  logic [AW-1:0] cur_dst;
  logic [AW-1:0] remaining;
  logic [DW-1:0] wdata_reg;

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    if (32'(a) == 32'(DEPTH - 1)) return '0;
    return a + AW'(1);
  endfunction

  // Start addresses beyond the implemented RAM are folded back once.
  function automatic logic [AW-1:0] addr_fold(input logic [AW-1:0] a);
    if (32'(a) >= 32'(DEPTH)) return a - AW'(DEPTH);
    return a;
  endfunction

  // The read issued in RD returns during WR, so the copied word cannot be
  // registered in time; it is passed straight from the RAM output to its input.
  assign mem_wdata = (state == WR) ? mem_rdata : wdata_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_cs_b  <= 1'b1;
      mem_rnw   <= 1'b1;
      mem_addr  <= '0;
      wdata_reg <= '0;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur_src   <= addr_fold(src);
            cur_dst   <= addr_fold(dst);
            remaining <= len;
            wdata_reg <= fill_val;
            if (len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else if (!mode) begin
              state    <= RD;
              busy     <= 1'b1;
              mem_cs_b <= 1'b0;
              mem_rnw  <= 1'b1;
              mem_addr <= addr_fold(src);
            end else begin
              state    <= FILL;
              busy     <= 1'b1;
              mem_cs_b <= 1'b0;
              mem_rnw  <= 1'b0;
              mem_addr <= addr_fold(dst);
            end
          end
        end

        RD: begin
          state    <= WR;
          mem_rnw  <= 1'b0;
          mem_addr <= cur_dst;
        end

        WR: begin
          cur_src   <= addr_inc(cur_src);
          cur_dst   <= addr_inc(cur_dst);
          remaining <= remaining - AW'(1);
          if (remaining == AW'(1)) begin
            state    <= FIN;
            busy     <= 1'b0;
            done     <= 1'b1;
            mem_cs_b <= 1'b1;
            mem_rnw  <= 1'b1;
          end else begin
            state    <= RD;
            mem_rnw  <= 1'b1;
            mem_addr <= addr_inc(cur_src);
          end
        end

        FILL: begin
          cur_dst   <= addr_inc(cur_dst);
          remaining <= remaining - AW'(1);
          if (remaining == AW'(1)) begin
            state    <= FIN;
            busy     <= 1'b0;
            done     <= 1'b1;
            mem_cs_b <= 1'b1;
            mem_rnw  <= 1'b1;
          end else begin
            mem_addr <= addr_inc(cur_dst);
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          mem_cs_b <= 1'b1;
          mem_rnw  <= 1'b1;
        end
      endcase
    end
  end

endmodule
